cu_bubble_stage: RTL and testbench



---
 rtl/cu_bubble_stage_if.sv | 31 +++
 rtl/cu_bubble_stage.sv | 120 ++++++++++++
 tb/tb_cu_bubble_stage.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cu_bubble_stage_if.sv
// Control-bundle handshake between the control unit / hazard logic and the
// bubble stage feeding the ID/EX register.
interface cu_bubble_stage_if #(
  parameter int unsigned CTRL_W      = 13,
  parameter int unsigned MAX_BUBBLES = 4,
  parameter int unsigned CNT_W       = $clog2(MAX_BUBBLES + 1),
  parameter int unsigned STAT_W      = 16
);
  logic [CTRL_W-1:0] ctrl_in;
  logic              in_valid;
  logic              hazard;
  logic              bubble_req;
  logic [CNT_W-1:0]  bubble_len;
  logic              stall;
  logic              flush;
  logic [CTRL_W-1:0] ctrl_out;
  logic              out_valid;
  logic              bubbling;
  logic              upstream_stall;
  logic [STAT_W-1:0] bubble_total;

  modport master (
    output ctrl_in, in_valid, hazard, bubble_req, bubble_len, stall, flush,
    input  ctrl_out, out_valid, bubbling, upstream_stall, bubble_total
  );

  modport slave (
    input  ctrl_in, in_valid, hazard, bubble_req, bubble_len, stall, flush,
    output ctrl_out, out_valid, bubbling, upstream_stall, bubble_total
  );
endinterface

// File: rtl/cu_bubble_stage.sv
// Registered control-word stage: passes the control bundle or inserts NOP
// bubbles (single or burst), with stall/flush and a saturating bubble count.
module cu_bubble_stage #(
  parameter int unsigned       CTRL_W      = 13,
  parameter int unsigned       MAX_BUBBLES = 4,
  parameter int unsigned       CNT_W       = $clog2(MAX_BUBBLES + 1),
  parameter int unsigned       STAT_W      = 16,
  parameter logic [CTRL_W-1:0] NOP         = '0
) (
  input logic              clk,
  input logic              rst_n,
  cu_bubble_stage_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_BUBBLES);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  generate
    if (MAX_BUBBLES < 1) begin : g_bad_max
      $error("cu_bubble_stage: MAX_BUBBLES must be at least 1");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [STAT_W-1:0] total_q, total_d;

  logic              burst_req;
  logic              insert_bubble;
  logic [CNT_W-1:0]  burst_n;

  assign burst_req     = bus.bubble_req && (bus.bubble_len != '0);
  assign burst_n       = (bus.bubble_len > MAX_N) ? MAX_N : bus.bubble_len;
  // A burst in progress swallows any new request or hazard.
  assign insert_bubble = (state_q == BURST) || burst_req || bus.hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= NOP;
      valid_q <= 1'b0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      total_q <= total_d;
    end
  end

  // cnt holds the bubbles still owed after the one being captured now.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (!bus.stall) begin
      unique case (state_q)
        BURST: begin
          if (cnt_q <= ONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        IDLE: begin
          if (burst_req && (burst_n > ONE)) begin
            state_d = BURST;
            cnt_d   = burst_n - ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    total_d = total_q;
    if (bus.flush) begin
      ctrl_d  = NOP;
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      if (insert_bubble) begin
        ctrl_d  = NOP;
        valid_d = 1'b0;
        if (total_q != '1) begin
          total_d = total_q + STAT_W'(1);
        end
      end else begin
        ctrl_d  = bus.in_valid ? bus.ctrl_in : NOP;
        valid_d = bus.in_valid;
      end
    end
  end

  assign bus.ctrl_out       = ctrl_q;
  assign bus.out_valid      = valid_q;
  assign bus.bubbling       = (state_q == BURST);
  assign bus.bubble_total   = total_q;
  assign bus.upstream_stall = !bus.flush &&
                              (bus.stall || (state_q == BURST) ||
                               ((state_q == IDLE) && (burst_req || bus.hazard)));

endmodule

// File: tb/tb_cu_bubble_stage.sv
// Directed bench for cu_bubble_stage: default instance plus a 4-bit
// statistics instance for the saturation case.
module tb_cu_bubble_stage;

  localparam int unsigned CTRL_W = 13;
  localparam int unsigned MAXB   = 4;
  localparam int unsigned CNT_W  = $clog2(MAXB + 1);

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  cu_bubble_stage_if #(.CTRL_W(CTRL_W), .MAX_BUBBLES(MAXB), .CNT_W(CNT_W), .STAT_W(16)) bus ();
  cu_bubble_stage_if #(.CTRL_W(CTRL_W), .MAX_BUBBLES(MAXB), .CNT_W(CNT_W), .STAT_W(4))  bus2 ();

  cu_bubble_stage #(.CTRL_W(CTRL_W), .MAX_BUBBLES(MAXB), .CNT_W(CNT_W), .STAT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  cu_bubble_stage #(.CTRL_W(CTRL_W), .MAX_BUBBLES(MAXB), .CNT_W(CNT_W), .STAT_W(4)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ctrl_in    = '0;
    bus.in_valid   = 1'b0;
    bus.hazard     = 1'b0;
    bus.bubble_req = 1'b0;
    bus.bubble_len = '0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
  endtask

  int bub_cnt;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b1;
    idle_inputs();
    bus2.ctrl_in    = '0;
    bus2.in_valid   = 1'b0;
    bus2.hazard     = 1'b0;
    bus2.bubble_req = 1'b0;
    bus2.bubble_len = '0;
    bus2.stall      = 1'b0;
    bus2.flush      = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_ctrl",   32'(bus.ctrl_out), 32'h0);
    check("rst_valid",  32'(bus.out_valid), 32'h0);
    check("rst_bubbl",  32'(bus.bubbling), 32'h0);
    check("rst_total",  32'(bus.bubble_total), 32'h0);
    check("rst_ustall", 32'(bus.upstream_stall), 32'h0);
    #9 rst_n = 1'b1;

    // Hazard for one cycle, then pass-through
    bus.ctrl_in = 13'h1F3; bus.in_valid = 1'b1; bus.hazard = 1'b1;
    #1 check("hz_ustall_hi", 32'(bus.upstream_stall), 32'h1);
    tick();
    check("hz_ctrl",  32'(bus.ctrl_out), 32'h0);
    check("hz_valid", 32'(bus.out_valid), 32'h0);
    check("hz_total", 32'(bus.bubble_total), 32'd1);
    bus.hazard = 1'b0;
    #1 check("hz_ustall_lo", 32'(bus.upstream_stall), 32'h0);
    tick();
    check("pass_ctrl",  32'(bus.ctrl_out), 32'h1F3);
    check("pass_valid", 32'(bus.out_valid), 32'h1);
    check("pass_total", 32'(bus.bubble_total), 32'd1);

    // Burst request of 7, clamped to 4
    bus.ctrl_in = 13'h0C3; bus.bubble_req = 1'b1; bus.bubble_len = 3'd7;
    bub_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1 check("clamp_ustall", 32'(bus.upstream_stall), 32'h1);
      tick();
      check("clamp_ctrl",  32'(bus.ctrl_out), 32'h0);
      check("clamp_valid", 32'(bus.out_valid), 32'h0);
      if (bus.bubbling) bub_cnt++;
      bus.bubble_req = 1'b0; bus.bubble_len = '0;
    end
    check("clamp_bubbling_cycles", 32'(bub_cnt), 32'd3);
    check("clamp_total", 32'(bus.bubble_total), 32'd5);
    #1 check("clamp_ustall_end", 32'(bus.upstream_stall), 32'h0);
    tick();
    check("clamp_pass", 32'(bus.ctrl_out), 32'h0C3);
    check("clamp_pass_valid", 32'(bus.out_valid), 32'h1);

    // Burst of 3 with a 2-cycle stall after the first bubble
    bus.ctrl_in = 13'h155; bus.bubble_req = 1'b1; bus.bubble_len = 3'd3;
    tick();
    check("stb_b1_total", 32'(bus.bubble_total), 32'd6);
    check("stb_b1_bubbl", 32'(bus.bubbling), 32'h1);
    bus.bubble_req = 1'b0; bus.bubble_len = '0; bus.stall = 1'b1;
    #1 check("stb_ustall", 32'(bus.upstream_stall), 32'h1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stb_hold_ctrl",  32'(bus.ctrl_out), 32'h0);
      check("stb_hold_total", 32'(bus.bubble_total), 32'd6);
      check("stb_hold_bubbl", 32'(bus.bubbling), 32'h1);
    end
    bus.stall = 1'b0;
    tick();
    check("stb_b2_total", 32'(bus.bubble_total), 32'd7);
    check("stb_b2_bubbl", 32'(bus.bubbling), 32'h1);
    tick();
    check("stb_b3_total", 32'(bus.bubble_total), 32'd8);
    check("stb_b3_bubbl", 32'(bus.bubbling), 32'h0);
    check("stb_b3_ctrl",  32'(bus.ctrl_out), 32'h0);
    tick();
    check("stb_pass", 32'(bus.ctrl_out), 32'h155);

    // Flush together with stall mid-burst
    bus.ctrl_in = 13'h0AA; bus.bubble_req = 1'b1; bus.bubble_len = 3'd4;
    tick();
    bus.bubble_req = 1'b0; bus.bubble_len = '0;
    tick();
    check("fl_pre_total", 32'(bus.bubble_total), 32'd10);
    bus.flush = 1'b1; bus.stall = 1'b1;
    #1 check("fl_ustall", 32'(bus.upstream_stall), 32'h0);
    tick();
    check("fl_bubbl", 32'(bus.bubbling), 32'h0);
    check("fl_valid", 32'(bus.out_valid), 32'h0);
    check("fl_ctrl",  32'(bus.ctrl_out), 32'h0);
    check("fl_total", 32'(bus.bubble_total), 32'd10);
    bus.flush = 1'b0; bus.stall = 1'b0;
    #1 check("fl_ustall_after", 32'(bus.upstream_stall), 32'h0);
    tick();
    check("fl_pass", 32'(bus.ctrl_out), 32'h0AA);
    check("fl_pass_valid", 32'(bus.out_valid), 32'h1);

    // Plain stall holds a valid word; invalid input gives NOP
    bus.ctrl_in = 13'h111; bus.stall = 1'b1;
    tick();
    check("st_hold", 32'(bus.ctrl_out), 32'h0AA);
    bus.stall = 1'b0;
    tick();
    check("st_release", 32'(bus.ctrl_out), 32'h111);
    bus.ctrl_in = 13'h1FF; bus.in_valid = 1'b0;
    tick();
    check("inv_ctrl",  32'(bus.ctrl_out), 32'h0);
    check("inv_valid", 32'(bus.out_valid), 32'h0);
    check("inv_total", 32'(bus.bubble_total), 32'd10);

    // Hazard absorbed into a burst of 2
    bus.ctrl_in = 13'h0F0; bus.in_valid = 1'b1;
    bus.hazard = 1'b1; bus.bubble_req = 1'b1; bus.bubble_len = 3'd2;
    tick();
    check("hb_total1", 32'(bus.bubble_total), 32'd11);
    check("hb_bubbl1", 32'(bus.bubbling), 32'h1);
    bus.hazard = 1'b0; bus.bubble_req = 1'b0; bus.bubble_len = '0;
    tick();
    check("hb_total2", 32'(bus.bubble_total), 32'd12);
    check("hb_bubbl2", 32'(bus.bubbling), 32'h0);
    tick();
    check("hb_pass", 32'(bus.ctrl_out), 32'h0F0);

    // bubble_req with length 0 is no request
    bus.ctrl_in = 13'h123; bus.bubble_req = 1'b1; bus.bubble_len = '0;
    #1 check("len0_ustall", 32'(bus.upstream_stall), 32'h0);
    tick();
    check("len0_pass",  32'(bus.ctrl_out), 32'h123);
    check("len0_total", 32'(bus.bubble_total), 32'd12);
    bus.bubble_req = 1'b0;

    // Asynchronous reset while bubbling
    bus.bubble_req = 1'b1; bus.bubble_len = 3'd3;
    tick();
    check("rmb_bubbl_pre", 32'(bus.bubbling), 32'h1);
    bus.bubble_req = 1'b0; bus.bubble_len = '0;
    bus.ctrl_in = 13'h0A5; bus.in_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rmb_ctrl",   32'(bus.ctrl_out), 32'h0);
    check("rmb_valid",  32'(bus.out_valid), 32'h0);
    check("rmb_bubbl",  32'(bus.bubbling), 32'h0);
    check("rmb_total",  32'(bus.bubble_total), 32'h0);
    check("rmb_ustall", 32'(bus.upstream_stall), 32'h0);
    #1 rst_n = 1'b1;
    tick();
    check("rmb_pass",  32'(bus.ctrl_out), 32'h0A5);
    check("rmb_pass_valid", 32'(bus.out_valid), 32'h1);

    // Saturation on the 4-bit statistics instance
    for (int i = 1; i <= 20; i++) begin
      bus2.hazard = 1'b1;
      tick();
      bus2.hazard = 1'b0;
      tick();
      if (i == 5)  check("sat_5",  32'(bus2.bubble_total), 32'h5);
      if (i == 15) check("sat_15", 32'(bus2.bubble_total), 32'hF);
    end
    check("sat_20", 32'(bus2.bubble_total), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
